// File: rtl/matrix_mem_engine.sv
// matrix_mem_engine: multi-matrix scratch memory with host port and a
// one-element-per-cycle CLEAR / COPY / TRANSPOSE-COPY command engine.
module matrix_mem_engine #(
  parameter int DATA_W   = 8,
  parameter int DIM      = 3,
  parameter int NUM_MATS = 3,
  parameter int MSEL_W   = 2,
  parameter int IDX_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MSEL_W-1:0] matrix_select,
  input  logic [IDX_W-1:0]  row,
  input  logic [IDX_W-1:0]  col,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [MSEL_W-1:0] cmd_src,
  input  logic [MSEL_W-1:0] cmd_dst,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_CPY = 2'b01;
  localparam logic [1:0] OP_TRN = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [MSEL_W:0]  LP_NM   = (MSEL_W+1)'(NUM_MATS);
  localparam logic [IDX_W:0]   LP_DIM  = (IDX_W+1)'(DIM);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(DIM-1);

  logic [DATA_W-1:0] r_mem [NUM_MATS][DIM][DIM];
  logic [0:0]        r_state;
  logic [1:0]        r_op;
  logic [MSEL_W-1:0] r_src, r_dst;
  logic [IDX_W-1:0]  r_r, r_c;
  logic [DATA_W-1:0] r_read_data;
  logic              r_read_valid, r_done, r_error;

  logic              w_host_ok, w_bad, w_last_c, w_last;
  logic [DATA_W-1:0] w_rd_val, w_eng_val;
  logic [IDX_W-1:0]  w_wr_r, w_wr_c;

  assign w_host_ok = ({1'b0, matrix_select} < LP_NM) && ({1'b0, row} < LP_DIM) && ({1'b0, col} < LP_DIM);
  assign w_rd_val  = w_host_ok ? r_mem[matrix_select][row][col] : '0;
  // Source index only matters for COPY/TRANSPOSE; an in-place transpose would corrupt itself.
  assign w_bad = (cmd_op == OP_RSV) || ({1'b0, cmd_dst} >= LP_NM) ||
                 ((cmd_op != OP_CLR) && ({1'b0, cmd_src} >= LP_NM)) ||
                 ((cmd_op == OP_TRN) && (cmd_src == cmd_dst));
  assign w_last_c  = (r_c == LP_LAST);
  assign w_last    = w_last_c && (r_r == LP_LAST);
  assign w_eng_val = (r_op == OP_CPY || r_op == OP_TRN) ? r_mem[r_src][r_r][r_c] : '0;
  assign w_wr_r    = (r_op == OP_TRN) ? r_c : r_r;
  assign w_wr_c    = (r_op == OP_TRN) ? r_r : r_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUM_MATS; m++)
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++)
            r_mem[m][i][j] <= '0;
      r_state      <= S_IDLE;
      r_op         <= OP_CLR;
      r_src        <= '0;
      r_dst        <= '0;
      r_r          <= '0;
      r_c          <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      if (r_state == S_IDLE) begin
        if (write_enable && w_host_ok) r_mem[matrix_select][row][col] <= write_data;
        if (read_enable) begin
          r_read_data  <= w_rd_val;
          r_read_valid <= 1'b1;
        end
        if (cmd_valid) begin
          if (w_bad) r_error <= 1'b1;
          else begin
            r_op    <= cmd_op;
            r_src   <= cmd_src;
            r_dst   <= cmd_dst;
            r_r     <= '0;
            r_c     <= '0;
            r_state <= S_RUN;
          end
        end
      end else begin
        r_mem[r_dst][w_wr_r][w_wr_c] <= w_eng_val;
        r_c <= w_last_c ? '0 : r_c + 1'b1;
        r_r <= w_last_c ? r_r + 1'b1 : r_r;
        if (w_last) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign error      = r_error;
endmodule

// File: doc/matrix_mem_engine.md
Name: matrix_mem_engine

Overview:
- Parametrised multi-matrix scratch memory: NUM_MATS square DIM x DIM matrices of DATA_W-bit elements.
- Host port: registered read, single-cycle write.
- Built-in command engine runs CLEAR, COPY and TRANSPOSE-COPY, one element per cycle.
- Sits between the matrix-operation datapath and the input/display logic; operand staging and result clearing no longer need host loops.

Parameters:
DATA_W, 8, element width in bits
DIM, 3, matrix dimension (rows = cols = DIM), DIM >= 2
NUM_MATS, 3, number of matrices stored
MSEL_W, 2, matrix index width, must be >= clog2(NUM_MATS)
IDX_W, 2, row/column index width, must be >= clog2(DIM)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
matrix_select  input  MSEL_W  host matrix index
row  input  IDX_W  host row index
col  input  IDX_W  host column index
write_enable  input  1  host write strobe
write_data  input  DATA_W  host write data
read_enable  input  1  host read strobe
read_data  output  DATA_W  registered read data
read_valid  output  1  one-cycle pulse: read_data updated
cmd_valid  input  1  command request
cmd_op  input  2  00 CLEAR, 01 COPY, 10 TRANSPOSE, 11 reserved
cmd_src  input  MSEL_W  source matrix (COPY/TRANSPOSE)
cmd_dst  input  MSEL_W  destination matrix
cmd_ready  output  1  engine idle, command can be accepted
busy  output  1  engine running
done  output  1  one-cycle pulse: command completed
error  output  1  one-cycle pulse: command rejected

Behaviour:
- Reset (async, any time, including mid-command): all elements = 0; read_data = 0; read_valid = 0; busy = 0; done = 0; error = 0; cmd_ready = 1; FSM = IDLE. A running command is aborted.
- States: IDLE, RUN. cmd_ready = (state == IDLE). busy = (state == RUN).
- Host write:
  - Performed only when write_enable && !busy.
  - Writes memory[matrix_select][row][col] at the edge.
  - Ignored if any index is out of range (matrix_select >= NUM_MATS, row or col >= DIM), or if busy.
- Host read:
  - Occurs when read_enable && !busy. At the edge, read_data <= element and read_valid <= 1 for one cycle.
  - Out-of-range index returns 0 with read_valid = 1.
  - Read-before-write: a same-edge write to the same address returns the old value.
  - read_data holds between reads. read_enable while busy is ignored (read_valid stays 0).
- Command acceptance: cmd_valid && cmd_ready at edge T.
  - Rejected with error = 1 for the cycle after T, no state change, stays IDLE, if any of:
    - cmd_op == 11
    - cmd_dst >= NUM_MATS
    - COPY/TRANSPOSE with cmd_src >= NUM_MATS
    - TRANSPOSE with cmd_src == cmd_dst
  - Otherwise src, dst and op are latched, state -> RUN, element counter (r, c) = (0, 0).
- RUN:
  - Element k = r*DIM + c is written at edge T+1+k, row-major; c wraps DIM-1 -> 0 and increments r.
  - CLEAR: dst[r][c] <= 0.
  - COPY: dst[r][c] <= src[r][c].
  - TRANSPOSE: dst[c][r] <= src[r][c].
  - Source is read combinationally in the same cycle.
  - COPY with src == dst is legal; contents are unchanged.
- Completion:
  - The last element is written at edge T+DIM*DIM.
  - At that edge: state -> IDLE, busy -> 0, done -> 1 for exactly one cycle, cmd_ready -> 1.
  - Latency: DIM*DIM cycles busy per command.
- Simultaneous events:
  - Host write in the acceptance cycle T executes (engine not yet busy) and is visible to the command.
  - cmd_valid during RUN is not accepted (cmd_ready = 0); the requester must hold it.
  - A new command may be accepted in the cycle done is high.
- Widths: no arithmetic on data; elements are stored and moved bit-exact.

Test Plan:
- Reset, then read all 27 addresses (DIM=3, NUM_MATS=3) -> every read_data = 0 with read_valid pulsed; cmd_ready = 1, busy = 0.
- Write M0 = 1..9 row-major, then read M0[1][2] -> read_data = 6 one edge after read_enable. Same-edge write 8'hAA and read of M0[1][2] -> old value 6 returned; next read returns 8'hAA.
- TRANSPOSE src=0 dst=1 -> busy high for exactly 9 cycles, done pulses once; M1[2][0] = 3 and M1[0][2] = 7. Host write and read during busy ignored; read_valid stays 0.
- COPY src=1 dst=2 followed by CLEAR dst=1 accepted in the done cycle -> M2 equals transpose of M0; M1 all 0 after 9 more cycles.
- TRANSPOSE src=dst=0, cmd_dst=3, and cmd_op=11 -> each gives a single error pulse, no done, memory unchanged, busy stays 0.
- Assert reset asynchronously during cycle 4 of CLEAR dst=0 -> busy, done and error = 0 immediately; all memory reads 0 afterwards; a new command is accepted on the next cycle.
